// File: rtl/pcie_ring_writer_mc.sv
`default_nettype none
// ============================================================================
//  Module   : pcie_ring_writer_mc
//  Purpose  : Multi-channel PCIe ring-buffer writer. NUM_CH Avalon-ST packet
//             inputs are round-robin arbitrated, one packet at a time, into
//             per-channel circular regions of a shared ring RAM. Packets that
//             do not fit, arrive while disabled, are orphaned (no sop) or are
//             oversize are dropped. Every written packet produces one update
//             pulse carrying channel, size and the new tail.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             in_data/sop/eop/valid/empty, in_ready - per-channel packet inputs
//             disable_pcie        - drop every new packet when high
//             rb_head             - host read pointer per channel (flits)
//             rb_almost_full      - ring RAM write backpressure
//             rb_wr_data/addr/en  - registered ring RAM write port
//             rb_update_*         - one-cycle packet-written message
//             pkt_cnt, drop_cnt   - per-channel written / dropped counters
//  Revision : 1.0 - initial release
// ============================================================================
module pcie_ring_writer_mc #(
  parameter int NUM_CH        = 4,
  parameter int DATA_W        = 512,
  parameter int RING_AW       = 10,
  parameter int MAX_PKT_FLITS = 32,
  parameter int CNT_W         = 32,
  localparam int CH_W         = $clog2(NUM_CH),
  localparam int SZ_W         = $clog2(MAX_PKT_FLITS) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*DATA_W-1:0]  in_data,
  input  logic [NUM_CH-1:0]         in_sop,
  input  logic [NUM_CH-1:0]         in_eop,
  input  logic [NUM_CH-1:0]         in_valid,
  input  logic [NUM_CH*6-1:0]       in_empty,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic                      disable_pcie,
  input  logic [NUM_CH*RING_AW-1:0] rb_head,
  input  logic                      rb_almost_full,
  output logic [DATA_W-1:0]         rb_wr_data,
  output logic [CH_W+RING_AW-1:0]   rb_wr_addr,
  output logic                      rb_wr_en,
  output logic                      rb_update_valid,
  output logic [CH_W-1:0]           rb_update_ch,
  output logic [SZ_W-1:0]           rb_update_size,
  output logic [RING_AW-1:0]        rb_update_tail,
  output logic [NUM_CH*CNT_W-1:0]   pkt_cnt,
  output logic [NUM_CH*CNT_W-1:0]   drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER   = 2'd1,
    ST_DROP   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  state_t                    state, state_nxt;
  logic [CH_W-1:0]           rr_ptr;
  logic [CH_W-1:0]           g;
  logic [SZ_W-1:0]           bcnt;
  logic [SZ_W-1:0]           pend_size;
  logic [NUM_CH*RING_AW-1:0] tail_all;

  logic                      found;
  logic [CH_W-1:0]           grant;
  logic [CH_W-1:0]           idx;
  logic [RING_AW-1:0]        grant_tail;
  logic [RING_AW-1:0]        cur_tail;
  logic [RING_AW-1:0]        free_sp;
  logic                      space_low;
  logic                      acc;
  logic                      last_slot;
  logic                      tail_we;
  logic [RING_AW-1:0]        tail_new;
  logic                      pkt_inc;
  logic                      drop_inc;
  logic [CH_W-1:0]           drop_ch;

  // Empty-byte count is meaningless here: eop flits are written whole.
  logic unused_empty;
  assign unused_empty = ^in_empty;

  // Round-robin scan: walking from the far end back to rr_ptr leaves the
  // first requestor at or after rr_ptr as the winner.
  always_comb begin
    found = 1'b0;
    grant = rr_ptr;
    idx   = rr_ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = rr_ptr + CH_W'(i);
      if (in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign grant_tail = tail_all[grant*RING_AW +: RING_AW];
  assign cur_tail   = tail_all[g*RING_AW +: RING_AW];
  // One slot is kept empty so that head == tail always means "ring empty".
  assign free_sp    = rb_head[grant*RING_AW +: RING_AW] - grant_tail - RING_AW'(1);
  assign space_low  = (int'(free_sp) < MAX_PKT_FLITS);

  always_comb begin
    in_ready = '0;
    if (state == ST_XFER)
      in_ready[g] = !rb_almost_full;
    else if (state == ST_DROP)
      in_ready[g] = 1'b1;
  end

  assign acc       = in_valid[g] & in_ready[g];
  assign last_slot = (bcnt == SZ_W'(MAX_PKT_FLITS - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (found) begin
          if (!in_sop[grant] || disable_pcie || space_low) state_nxt = ST_DROP;
          else                                             state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (acc) begin
          if (in_eop[g])      state_nxt = ST_UPDATE;
          else if (last_slot) state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (acc && in_eop[g]) state_nxt = ST_IDLE;
      end
      ST_UPDATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Per-channel state update strobes.
  assign tail_we  = (state == ST_XFER) && acc && in_eop[g];
  assign tail_new = cur_tail + RING_AW'(bcnt) + RING_AW'(1);
  assign pkt_inc  = (state == ST_UPDATE);
  // An oversize packet is counted when it overflows; a rejected packet is
  // counted once when it is sent to DROP from IDLE.
  assign drop_inc = ((state == ST_IDLE) && found && (state_nxt == ST_DROP)) ||
                    ((state == ST_XFER) && acc && !in_eop[g] && last_slot);
  assign drop_ch  = (state == ST_IDLE) ? grant : g;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr          <= '0;
      g               <= '0;
      bcnt            <= '0;
      pend_size       <= '0;
      rb_wr_en        <= 1'b0;
      rb_wr_addr      <= '0;
      rb_wr_data      <= '0;
      rb_update_valid <= 1'b0;
      rb_update_ch    <= '0;
      rb_update_size  <= '0;
      rb_update_tail  <= '0;
    end else begin
      rb_wr_en        <= 1'b0;
      rb_update_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            g      <= grant;
            rr_ptr <= grant + 1'b1;
            bcnt   <= '0;
          end
        end
        ST_XFER: begin
          if (acc) begin
            rb_wr_en   <= 1'b1;
            rb_wr_addr <= {g, cur_tail + RING_AW'(bcnt)};
            rb_wr_data <= in_data[g*DATA_W +: DATA_W];
            bcnt       <= bcnt + 1'b1;
            if (in_eop[g]) pend_size <= bcnt + 1'b1;
          end
        end
        ST_UPDATE: begin
          rb_update_valid <= 1'b1;
          rb_update_ch    <= g;
          rb_update_size  <= pend_size;
          rb_update_tail  <= cur_tail;
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [RING_AW-1:0] tail_q;
      logic [CNT_W-1:0]   pkt_q;
      logic [CNT_W-1:0]   drop_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tail_q <= '0;
          pkt_q  <= '0;
          drop_q <= '0;
        end else begin
          if (tail_we && (g == CH_W'(c)))        tail_q <= tail_new;
          if (pkt_inc && (g == CH_W'(c)))        pkt_q  <= pkt_q + 1'b1;
          if (drop_inc && (drop_ch == CH_W'(c))) drop_q <= drop_q + 1'b1;
        end
      end

      assign tail_all[c*RING_AW +: RING_AW] = tail_q;
      assign pkt_cnt[c*CNT_W +: CNT_W]      = pkt_q;
      assign drop_cnt[c*CNT_W +: CNT_W]     = drop_q;
    end
  endgenerate

endmodule
`default_nettype wire
